lock_scheduler: RTL and testbench

LOCK_SCHEDULER -- requirements
Module: lock_scheduler

---
 rtl/lock_pkg.sv | 34 +++
 rtl/sync_ff.sv | 23 ++
 rtl/lock_scheduler.sv | 117 +++++++++++
 tb/tb_lock_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared state type, parameter defaults and round-robin pick helper
package lock_pkg;

    localparam int DEF_NUM_CLIENTS = 4;
    localparam int DEF_HOLD_MAX    = 15;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACQ  = 2'd1,
        ST_HOLD = 2'd2,
        ST_REL  = 2'd3
    } lock_state_t;

    // First set bit of req at or after ptr, wrapping within n clients.
    function automatic int rr_pick(input logic [7:0] req, input int ptr, input int n);
        int pick;
        int idx;
        pick = 0;
        for (int k = 7; k >= 0; k--) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (req[idx[2:0]]) begin
                    pick = idx;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-flop synchronizer for a single asynchronous bit
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/lock_scheduler.sv
// rtl/lock_scheduler.sv - round-robin client scheduler in front of a 4-phase asynchronous lock
module lock_scheduler
    import lock_pkg::*;
#(
    parameter int NUM_CLIENTS = DEF_NUM_CLIENTS,
    parameter int HOLD_MAX    = DEF_HOLD_MAX,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_CLIENTS-1:0]         cli_req,
    output logic [NUM_CLIENTS-1:0]         cli_gnt,
    output logic [$clog2(NUM_CLIENTS)-1:0] gnt_id,
    output logic                           lock_req,
    input  logic                           lock_ack,
    output logic                           timeout
);

    localparam int ID_W = $clog2(NUM_CLIENTS);

    lock_state_t            state, state_nxt;
    logic [ID_W-1:0]        sel, sel_nxt;
    logic [ID_W-1:0]        rr_ptr, rr_ptr_nxt;
    logic [7:0]             cnt, cnt_nxt;
    logic [1:0]             warm;
    logic                   warm_done;
    logic                   ack_s;
    logic [NUM_CLIENTS-1:0] gnt_nxt;
    logic                   lr_nxt;
    logic                   to_nxt;

    (* keep_hierarchy = "yes" *)
    sync_ff #(
        .STAGES(SYNC_STAGES)
    ) u_ack_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (lock_ack),
        .q    (ack_s)
    );

    // The synchronizer resets to zero, so ack_s is not trustworthy until it has
    // refilled; a lock still held from before reset must not look released.
    assign warm_done = (warm == 2'(SYNC_STAGES));

    always_comb begin
        state_nxt  = state;
        sel_nxt    = sel;
        rr_ptr_nxt = rr_ptr;
        cnt_nxt    = cnt;
        to_nxt     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (warm_done && !ack_s && (|cli_req)) begin
                    sel_nxt   = ID_W'(rr_pick(8'(cli_req), int'(rr_ptr), NUM_CLIENTS));
                    state_nxt = ST_ACQ;
                end
            end
            ST_ACQ: begin
                if (ack_s) begin
                    if (cli_req[sel]) begin
                        state_nxt = ST_HOLD;
                        cnt_nxt   = 8'd0;
                    end else begin
                        state_nxt = ST_REL;
                    end
                end
            end
            ST_HOLD: begin
                if (!cli_req[sel]) begin
                    state_nxt = ST_REL;
                end else if (cnt == 8'(HOLD_MAX - 1)) begin
                    state_nxt = ST_REL;
                    to_nxt    = 1'b1;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            ST_REL: begin
                if (!ack_s) begin
                    rr_ptr_nxt = (sel == ID_W'(NUM_CLIENTS - 1)) ? '0 : sel + ID_W'(1);
                    state_nxt  = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        lr_nxt  = (state_nxt == ST_ACQ) || (state_nxt == ST_HOLD);
        gnt_nxt = (state_nxt == ST_HOLD) ? (NUM_CLIENTS'(1) << sel_nxt) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            sel      <= '0;
            rr_ptr   <= '0;
            cnt      <= '0;
            warm     <= '0;
            cli_gnt  <= '0;
            lock_req <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            sel      <= sel_nxt;
            rr_ptr   <= rr_ptr_nxt;
            cnt      <= cnt_nxt;
            cli_gnt  <= gnt_nxt;
            lock_req <= lr_nxt;
            timeout  <= to_nxt;
            if (!warm_done) begin
                warm <= warm + 2'd1;
            end
        end
    end

    assign gnt_id = sel;

endmodule

// File: tb/tb_lock_scheduler.sv
// tb/tb_lock_scheduler.sv - randomized scoreboard bench for lock_scheduler
module tb_lock_scheduler;

    localparam int NC = 4;
    localparam int HM = 4;
    localparam int SS = 2;

    typedef struct {
        int id;
        int glen;
        bit to;
    } sess_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NC-1:0] cli_req = '0;
    logic [NC-1:0] cli_gnt;
    logic [1:0]    gnt_id;
    logic          lock_req;
    logic          lock_ack = 1'b0;
    logic          timeout;

    sess_t exp_q[$];
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    ack_rise_cyc = 0;
    bit    auto_ack = 1'b1;
    int    ack_lat = 1;
    int    blen[NC];
    int    seen[NC];
    int    model_ptr = 0;
    int    m, n;

    bit    in_sess, prev_lr, prev_ack, prev_to, rst_edge;
    sess_t cur, expd;
    int    rsp_cnt;
    bit    rsp_pend;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    lock_scheduler #(
        .NUM_CLIENTS(NC),
        .HOLD_MAX   (HM),
        .SYNC_STAGES(SS)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cli_req (cli_req),
        .cli_gnt (cli_gnt),
        .gnt_id  (gnt_id),
        .lock_req(lock_req),
        .lock_ack(lock_ack),
        .timeout (timeout)
    );

    task automatic check(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Asynchronous lock: follows lock_req after ack_lat cycles, mid-cycle.
    initial begin
        rsp_pend = 1'b0;
        rsp_cnt  = 0;
        forever begin
            @(posedge clk);
            #3;
            if (auto_ack && (lock_ack != lock_req)) begin
                if (!rsp_pend) begin
                    rsp_pend = 1'b1;
                    rsp_cnt  = ack_lat;
                end
                if (rsp_cnt == 0) begin
                    lock_ack = lock_req;
                    rsp_pend = 1'b0;
                    if (lock_ack) ack_rise_cyc = cyc;
                end else begin
                    rsp_cnt--;
                end
            end else begin
                rsp_pend = 1'b0;
            end
        end
    end

    // Clients: hold for blen grant cycles (0 = give up while waiting), drop on revoke.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < NC; i++) begin
                if (!rst_n) begin
                    seen[i] = 0;
                end else if (cli_req[i]) begin
                    if (blen[i] == 0) begin
                        if (lock_req && (gnt_id == 2'(i))) cli_req[i] = 1'b0;
                    end else if (cli_gnt[i]) begin
                        seen[i]++;
                        if (seen[i] >= blen[i]) cli_req[i] = 1'b0;
                    end else if (seen[i] > 0) begin
                        cli_req[i] = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: one record per lock_req session, compared against the scoreboard.
    initial begin
        in_sess  = 1'b0;
        prev_lr  = 1'b0;
        prev_ack = 1'b0;
        prev_to  = 1'b0;
        forever begin
            @(posedge clk);
            rst_edge = rst_n;
            #2;
            if (!rst_edge) begin
                in_sess = 1'b0;
                check((cli_gnt == '0) && !lock_req && !timeout && (gnt_id == 2'd0), "reset_state",
                      int'({cli_gnt, gnt_id, lock_req, timeout}), 0);
            end else begin
                check($onehot0(cli_gnt), "gnt_onehot", int'(cli_gnt), 0);
                if (cli_gnt != '0) check(lock_req, "gnt_implies_req", int'(lock_req), 1);
                if (lock_req != prev_lr) check(prev_ack == prev_lr, "req_phase", int'(prev_ack), int'(prev_lr));
                if (timeout) begin
                    check(!prev_to, "timeout_width", 2, 1);
                    check(!lock_req && prev_lr && (cli_gnt == '0), "timeout_release",
                          int'({lock_req, prev_lr}), 1);
                end
                if (lock_req && !prev_lr) begin
                    in_sess  = 1'b1;
                    cur.id   = int'(gnt_id);
                    cur.glen = 0;
                    cur.to   = 1'b0;
                end
                if (in_sess && (cli_gnt != '0)) begin
                    cur.glen++;
                    check(cli_gnt == (4'b0001 << cur.id), "gnt_owner", int'(cli_gnt), cur.id);
                    if (cur.glen == 1) check(cyc - ack_rise_cyc == SS + 1, "ack_to_gnt_latency",
                                             cyc - ack_rise_cyc, SS + 1);
                end
                if (in_sess && !lock_req && prev_lr) begin
                    in_sess = 1'b0;
                    cur.to  = timeout;
                    if (exp_q.size() == 0) begin
                        check(1'b0, "unexpected_session", cur.id, -1);
                    end else begin
                        expd = exp_q.pop_front();
                        check(cur.id == expd.id, "grant_id", cur.id, expd.id);
                        check(cur.glen == expd.glen, "grant_length", cur.glen, expd.glen);
                        check(cur.to == expd.to, "timeout_flag", int'(cur.to), int'(expd.to));
                    end
                end
            end
            prev_lr  = lock_req;
            prev_ack = dut.ack_s;
            prev_to  = timeout;
        end
    end

    // Reference: requesters of a batch are served once each, in cyclic order from the pointer.
    task automatic model_push(input logic [NC-1:0] mask);
        int last;
        last = model_ptr;
        for (int k = 0; k < NC; k++) begin
            int    idx;
            sess_t e;
            idx = (model_ptr + k) % NC;
            if (mask[idx]) begin
                e.id   = idx;
                e.glen = (blen[idx] == 0) ? 0 : ((blen[idx] < HM) ? blen[idx] : HM);
                e.to   = (blen[idx] > HM);
                exp_q.push_back(e);
                last = idx;
            end
        end
        model_ptr = (last + 1) % NC;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (!((cli_req == '0) && !lock_req && !lock_ack) && (w < 3000)) begin
            @(negedge clk);
            w++;
        end
        check(w < 3000, "idle_wait_bound", w, 3000);
        repeat (SS + 3) @(negedge clk);
    endtask

    task automatic run_batch(input logic [NC-1:0] mask);
        model_push(mask);
        for (int i = 0; i < NC; i++) seen[i] = 0;
        cli_req = mask;
        wait_idle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_ptr = 0;
        repeat (SS + 3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NC; i++) begin
            blen[i] = 0;
            seen[i] = 0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (SS + 3) @(negedge clk);

        // single client, lock answers 3 cycles after lock_req
        ack_lat = 3;
        blen[2] = 3;
        model_push(4'b0100);
        m = cyc;
        cli_req = 4'b0100;
        n = 0;
        while (!lock_req && (n < 50)) begin
            @(negedge clk);
            n++;
        end
        check(cyc == m + 1, "req_latency", cyc - m, 1);
        while ((cli_gnt == '0) && (n < 100)) begin
            @(negedge clk);
            n++;
        end
        check(cyc == m + 1 + 3 + SS + 1, "gnt_latency", cyc - m, 1 + 3 + SS + 1);
        check(cli_gnt == 4'b0100, "gnt_single", int'(cli_gnt), 4);
        check(gnt_id == 2'd2, "gnt_id_single", int'(gnt_id), 2);
        wait_idle();

        // round robin from a fresh pointer: 0,1,2,3 then 0 again
        do_reset();
        ack_lat = 1;
        for (int i = 0; i < NC; i++) blen[i] = 2;
        run_batch(4'b1111);
        run_batch(4'b0001);

        // timeout on client 1, then client 2 served
        blen[1] = 9;
        blen[2] = 2;
        run_batch(4'b0110);

        // abort: client 0 gives up while the lock is being acquired
        blen[0] = 0;
        ack_lat = 2;
        run_batch(4'b0001);

        // reset in the middle of a grant while the lock stays held
        blen[3] = 100;
        seen[3] = 0;
        cli_req = 4'b1000;
        n = 0;
        while (!cli_gnt[3] && (n < 100)) begin
            @(negedge clk);
            n++;
        end
        check(n < 100, "hold_reached", n, 100);
        auto_ack = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_ptr = 0;
        model_push(4'b1000);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check(!lock_req, "req_blocked_while_ack", int'(lock_req), 0);
        end
        lock_ack = 1'b0;
        auto_ack = 1'b1;
        wait_idle();

        // randomized batches
        for (int b = 0; b < 30; b++) begin
            for (int i = 0; i < NC; i++) begin
                blen[i] = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, HM + 2));
            end
            ack_lat = int'($urandom_range(0, 3));
            run_batch(4'($urandom_range(1, 15)));
        end

        check(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
